pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
Pipeline controller for the 5-stage RISC-V core. It takes the decoded control bundle from the ID-stage control unit and carries it through the ID/EX, EX/MEM and MEM/WB control registers. It detects load-use and control hazards and drives stall, flush and PC-select. It also generates the EX-stage operand forwarding selects and freezes the whole pipeline while data memory is not ready.

Parameters:
REG_AW, 5, register-address width
ALUC_W, 3, alu_control width
CNT_W, 16, width of the stall/flush event counters

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
id_regwrite  in  1  ID decoded regwrite
id_result_src  in  2  00 ALU, 01 load data, 10 PC+4
id_memwrite  in  1  ID store
id_alu_src  in  1  ID ALU B = immediate
id_alu_control  in  ALUC_W  ID ALU op
id_branch  in  1  ID conditional branch
id_jump  in  1  ID jump
id_rs1, id_rs2, id_rd  in  REG_AW  ID register addresses
ex_zero  in  1  ALU zero flag in EX
dmem_ready  in  1  data memory ready; low stretches the MEM access
stall_f, stall_d  out  1  hold PC and the IF/ID register
flush_d, flush_e  out  1  clear IF/ID, insert a bubble into ID/EX
pc_src  out  1  1 = PC takes the branch/jump target
fwd_a_e, fwd_b_e  out  2  00 regfile, 01 WB result, 10 MEM ALU result
ex_alu_control  out  ALUC_W  registered EX control
ex_alu_src  out  1  registered EX control
mem_memwrite  out  1  registered MEM control
mem_access  out  1  MEM stage holds a load or store
wb_regwrite  out  1  registered WB control
wb_result_src  out  2  registered WB control
wb_rd  out  REG_AW  registered WB destination
stall_cnt, flush_cnt  out  CNT_W  saturating event counters

Behaviour:
- Reset (async, rst_n=0): all control registers, including rd/rs fields, and both counters go to 0. The pipeline is then all bubbles, so every output is 0.
- Stage registers: ID/EX captures the id_* bundle; EX/MEM captures EX; MEM/WB captures MEM. Update is on the rising edge of clk.
- mem_access = mem_memwrite | (mem_result_src==01).
- freeze = mem_access & ~dmem_ready. While freeze is high:
  - all stage registers hold;
  - stall_f = stall_d = 1;
  - flush_d = flush_e = pc_src = 0;
  - the counters do not change.
- load_use = (ex_result_src==01) & (ex_rd!=0) & (ex_rd==id_rs1 | ex_rd==id_rs2).
- ctrl_taken = ex_jump | (ex_branch & ex_zero).
  - pc_src = ctrl_taken & ~freeze.
  - flush_d = pc_src.
  - flush_e = (pc_src | load_use) & ~freeze.
- stall_f = stall_d = freeze | (load_use & ~pc_src). The taken branch wins because the stalled instruction is on the wrong path.
- On flush_e, the ID/EX register loads an all-zero bubble (regwrite=0, memwrite=0, branch=0, jump=0, rd=0). EX/MEM and MEM/WB advance normally.
- Forwarding, evaluated independently for rs1_e→fwd_a_e and rs2_e→fwd_b_e:
  - 10 if mem_regwrite & mem_rd!=0 & mem_rd==rs_e;
  - else 01 if wb_regwrite & wb_rd!=0 & wb_rd==rs_e;
  - else 00.
  - MEM has priority over WB.
  - x0 never forwards.
- Latency:
  - control reaches EX one cycle after ID, MEM after two, WB after three;
  - a load-use costs exactly 1 bubble;
  - a taken branch or jump costs 2 flushed slots.
- Counters:
  - stall_cnt increments on each non-freeze cycle with load_use & ~pc_src;
  - flush_cnt increments on each cycle with pc_src;
  - both saturate at all-ones and do not wrap.
- rst_n asserted mid-stall or mid-freeze clears all state immediately, with no pending flush or stall afterwards.

Decomposition:
- Shared package holds:
  - result_src encodings: RES_ALU=00, RES_MEM=01, RES_PC4=10;
  - forward encodings: FWD_RF=00, FWD_WB=01, FWD_MEM=10;
  - REG_AW, ALUC_W;
  - a ctrl_bundle typedef: regwrite, result_src, memwrite, alu_src, alu_control, branch, jump, rd, rs1, rs2.
- One sub-module, fwd_sel, is natural. It is the combinational forwarding compare and is instantiated twice, once for A and once for B.

Test Plan:
- Forwarding: lw x5 in MEM→WB, then add x6 with rs1=x5 → with x5 in WB, fwd_a_e=01; add x7,x6,x6 → fwd_a_e=fwd_b_e=10 (MEM beats WB).
- Load-use: lw x5 followed immediately by add with rs2=x5 → one cycle with stall_f=stall_d=1 and flush_e=1; next cycle fwd_b_e=01; stall_cnt=1.
- Taken branch: beq with ex_zero=1 in EX → pc_src=flush_d=flush_e=1 for 1 cycle; flush_cnt=1. With ex_zero=0 → all three stay 0.
- Simultaneous events: taken jump in EX while ID holds a load-use dependent → stall_f=0, flush_d=flush_e=1, stall_cnt unchanged.
- Memory wait: sw in MEM with dmem_ready=0 for 3 cycles → stall_f=stall_d=1, all control registers frozen for 3 cycles, pc_src=0 even if the EX branch is taken; the branch resolves the cycle after dmem_ready=1.
- Reset and x0: rst_n pulsed low mid-freeze → all outputs 0 asynchronously; a writer with rd=x0 never produces fwd≠00 or load_use.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and the decoded control bundle for the pipeline controller.
package pipe_ctrl_pkg;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned ALUC_W = 3;

    // Writeback result source
    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    // EX operand forwarding select
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_e;

    // Control bundle produced by the ID-stage decoder and held in ID/EX
    typedef struct packed {
        logic              regwrite;
        result_src_e       result_src;
        logic              memwrite;
        logic              alu_src;
        logic [ALUC_W-1:0] alu_control;
        logic              branch;
        logic              jump;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
    } ctrl_bundle_t;

endpackage

// File: rtl/pipe_ctrl_fwd_sel.sv
// Forwarding select for one EX source operand; the MEM writer beats the WB writer.
module fwd_sel
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_AW-1:0] rs,
    input  logic              mem_regwrite,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              wb_regwrite,
    input  logic [REG_AW-1:0] wb_rd,
    output logic [1:0]        sel
);

    // Youngest in-flight writer wins; x0 is hardwired zero and never forwards
    always_comb begin
        sel = FWD_RF;
        if (mem_regwrite && (mem_rd != '0) && (mem_rd == rs)) begin
            sel = FWD_MEM;
        end else if (wb_regwrite && (wb_rd != '0) && (wb_rd == rs)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: carries ID control through EX/MEM/WB, resolves load-use and
// control hazards, drives forwarding selects and freezes on data-memory wait.
module pipe_ctrl #(
    parameter int unsigned REG_AW = pipe_ctrl_pkg::REG_AW,
    parameter int unsigned ALUC_W = pipe_ctrl_pkg::ALUC_W,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_regwrite,
    input  logic [1:0]        id_result_src,
    input  logic              id_memwrite,
    input  logic              id_alu_src,
    input  logic [ALUC_W-1:0] id_alu_control,
    input  logic              id_branch,
    input  logic              id_jump,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              ex_zero,
    input  logic              dmem_ready,
    output logic              stall_f,
    output logic              stall_d,
    output logic              flush_d,
    output logic              flush_e,
    output logic              pc_src,
    output logic [1:0]        fwd_a_e,
    output logic [1:0]        fwd_b_e,
    output logic [ALUC_W-1:0] ex_alu_control,
    output logic              ex_alu_src,
    output logic              mem_memwrite,
    output logic              mem_access,
    output logic              wb_regwrite,
    output logic [1:0]        wb_result_src,
    output logic [REG_AW-1:0] wb_rd,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    import pipe_ctrl_pkg::*;

    ctrl_bundle_t      id_ctrl;
    ctrl_bundle_t      ex_q;
    logic              mem_regwrite_q, mem_memwrite_q;
    result_src_e       mem_result_src_q;
    logic [REG_AW-1:0] mem_rd_q;
    logic              wb_regwrite_q;
    result_src_e       wb_result_src_q;
    logic [REG_AW-1:0] wb_rd_q;
    logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;

    logic freeze, load_use, ctrl_taken, stall_inc;

    // Pack the decoded ID inputs into a bundle
    always_comb begin
        id_ctrl             = '0;
        id_ctrl.regwrite    = id_regwrite;
        id_ctrl.result_src  = result_src_e'(id_result_src);
        id_ctrl.memwrite    = id_memwrite;
        id_ctrl.alu_src     = id_alu_src;
        id_ctrl.alu_control = id_alu_control;
        id_ctrl.branch      = id_branch;
        id_ctrl.jump        = id_jump;
        id_ctrl.rd          = id_rd;
        id_ctrl.rs1         = id_rs1;
        id_ctrl.rs2         = id_rs2;
    end

    // Hazard detection: memory freeze dominates, then a taken branch beats load-use
    always_comb begin
        mem_access = mem_memwrite_q | (mem_result_src_q == RES_MEM);
        freeze     = mem_access & ~dmem_ready;
        load_use   = (ex_q.result_src == RES_MEM) && (ex_q.rd != '0) &&
                     ((ex_q.rd == id_rs1) || (ex_q.rd == id_rs2));
        ctrl_taken = ex_q.jump | (ex_q.branch & ex_zero);
        pc_src     = ctrl_taken & ~freeze;
        flush_d    = pc_src;
        flush_e    = (pc_src | load_use) & ~freeze;
        stall_f    = freeze | (load_use & ~pc_src);
        stall_d    = stall_f;
        stall_inc  = ~freeze & load_use & ~pc_src;
    end

    // Stage registers: hold on freeze, bubble into ID/EX on flush_e
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q             <= '0;
            mem_regwrite_q   <= 1'b0;
            mem_memwrite_q   <= 1'b0;
            mem_result_src_q <= RES_ALU;
            mem_rd_q         <= '0;
            wb_regwrite_q    <= 1'b0;
            wb_result_src_q  <= RES_ALU;
            wb_rd_q          <= '0;
        end else if (!freeze) begin
            ex_q             <= flush_e ? '0 : id_ctrl;
            mem_regwrite_q   <= ex_q.regwrite;
            mem_memwrite_q   <= ex_q.memwrite;
            mem_result_src_q <= ex_q.result_src;
            mem_rd_q         <= ex_q.rd;
            wb_regwrite_q    <= mem_regwrite_q;
            wb_result_src_q  <= mem_result_src_q;
            wb_rd_q          <= mem_rd_q;
        end
    end

    // Saturating stall/flush event counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_inc && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (pc_src && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    fwd_sel u_fwd_a (
        .rs           (ex_q.rs1),
        .mem_regwrite (mem_regwrite_q),
        .mem_rd       (mem_rd_q),
        .wb_regwrite  (wb_regwrite_q),
        .wb_rd        (wb_rd_q),
        .sel          (fwd_a_e)
    );

    fwd_sel u_fwd_b (
        .rs           (ex_q.rs2),
        .mem_regwrite (mem_regwrite_q),
        .mem_rd       (mem_rd_q),
        .wb_regwrite  (wb_regwrite_q),
        .wb_rd        (wb_rd_q),
        .sel          (fwd_b_e)
    );

    assign ex_alu_control = ex_q.alu_control;
    assign ex_alu_src     = ex_q.alu_src;
    assign mem_memwrite   = mem_memwrite_q;
    assign wb_regwrite    = wb_regwrite_q;
    assign wb_result_src  = wb_result_src_q;
    assign wb_rd          = wb_rd_q;
    assign stall_cnt      = stall_cnt_q;
    assign flush_cnt      = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl; counters narrowed to 4 bits to reach saturation.
module tb_pipe_ctrl;

    localparam int unsigned CW = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_regwrite, id_memwrite, id_alu_src, id_branch, id_jump;
    logic [1:0] id_result_src;
    logic [2:0] id_alu_control;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       ex_zero, dmem_ready;
    logic       stall_f, stall_d, flush_d, flush_e, pc_src;
    logic [1:0] fwd_a_e, fwd_b_e;
    logic [2:0] ex_alu_control;
    logic       ex_alu_src, mem_memwrite, mem_access, wb_regwrite;
    logic [1:0] wb_result_src;
    logic [4:0] wb_rd;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int checks = 0;
    int failures = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    logic [7:0] wb_exp_q[$];
    logic [2:0] ex_exp_q[$];

    always #5 clk = ~clk;

    pipe_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_regwrite(id_regwrite), .id_result_src(id_result_src), .id_memwrite(id_memwrite),
        .id_alu_src(id_alu_src), .id_alu_control(id_alu_control), .id_branch(id_branch),
        .id_jump(id_jump), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .ex_zero(ex_zero), .dmem_ready(dmem_ready),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
        .pc_src(pc_src), .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
        .ex_alu_control(ex_alu_control), .ex_alu_src(ex_alu_src),
        .mem_memwrite(mem_memwrite), .mem_access(mem_access),
        .wb_regwrite(wb_regwrite), .wb_result_src(wb_result_src), .wb_rd(wb_rd),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic set_instr(input logic rw, input logic [1:0] rs, input logic mw,
                             input logic as, input logic [2:0] ac, input logic br,
                             input logic jp, input logic [4:0] r1, input logic [4:0] r2,
                             input logic [4:0] rd);
        id_regwrite = rw; id_result_src = rs; id_memwrite = mw; id_alu_src = as;
        id_alu_control = ac; id_branch = br; id_jump = jp;
        id_rs1 = r1; id_rs2 = r2; id_rd = rd;
    endtask

    task automatic set_nop();
        set_instr(1'b0, 2'b00, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        set_nop();
        ex_zero = 1'b0;
        dmem_ready = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ex_zero = 1'b0; dmem_ready = 1'b1;
        set_nop();
        #2;
        checks++; if (stall_f !== 1'b0) begin failures++; $display("FAIL rst_stall_f got=%0h exp=0", stall_f); end
        checks++; if (flush_e !== 1'b0) begin failures++; $display("FAIL rst_flush_e got=%0h exp=0", flush_e); end
        checks++; if (pc_src !== 1'b0) begin failures++; $display("FAIL rst_pc_src got=%0h exp=0", pc_src); end
        checks++; if ({fwd_a_e, fwd_b_e} !== 4'b0) begin failures++; $display("FAIL rst_fwd got=%0h exp=0", {fwd_a_e, fwd_b_e}); end
        checks++; if ({stall_cnt, flush_cnt} !== '0) begin failures++; $display("FAIL rst_cnt got=%0h exp=0", {stall_cnt, flush_cnt}); end
        // Registers must ignore the clock while reset is held
        set_instr(1'b1, 2'b01, 1'b1, 1'b1, 3'b111, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3);
        tick();
        checks++; if ({ex_alu_control, ex_alu_src, mem_memwrite, wb_regwrite, wb_rd} !== '0) begin
            failures++; $display("FAIL rst_hold got=%0h exp=0", {ex_alu_control, ex_alu_src, mem_memwrite, wb_regwrite, wb_rd}); end
        set_nop();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_forwarding();
        set_instr(1'b1, 2'b01, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 5'd1, 5'd0, 5'd5); // lw x5
        tick();
        set_nop();
        tick();
        set_instr(1'b1, 2'b00, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0, 5'd5, 5'd2, 5'd6); // add x6,x5,x2
        tick();
        checks++; if (fwd_a_e !== 2'b01) begin failures++; $display("FAIL fwd_wb_a got=%0h exp=1", fwd_a_e); end
        checks++; if (fwd_b_e !== 2'b00) begin failures++; $display("FAIL fwd_wb_b got=%0h exp=0", fwd_b_e); end
        checks++; if ({wb_regwrite, wb_result_src, wb_rd} !== {1'b1, 2'b01, 5'd5}) begin
            failures++; $display("FAIL wb_load got=%0h exp=%0h", {wb_regwrite, wb_result_src, wb_rd}, {1'b1, 2'b01, 5'd5}); end
        set_instr(1'b1, 2'b00, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0, 5'd0, 5'd0, 5'd6); // add x6,x0,x0
        tick();
        checks++; if ({fwd_a_e, fwd_b_e} !== 4'b0) begin failures++; $display("FAIL fwd_x0_src got=%0h exp=0", {fwd_a_e, fwd_b_e}); end
        set_instr(1'b1, 2'b00, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0, 5'd6, 5'd6, 5'd7); // add x7,x6,x6
        tick();
        checks++; if ({fwd_a_e, fwd_b_e} !== 4'b1010) begin failures++; $display("FAIL fwd_mem_prio got=%0h exp=a", {fwd_a_e, fwd_b_e}); end
        set_instr(1'b1, 2'b00, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0, 5'd6, 5'd9, 5'd8); // add x8,x6,x9
        tick();
        checks++; if ({fwd_a_e, fwd_b_e} !== 4'b0100) begin failures++; $display("FAIL fwd_wb_only got=%0h exp=4", {fwd_a_e, fwd_b_e}); end
        drain();
    endtask

    task automatic test_x0();
        set_instr(1'b1, 2'b01, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 5'd1, 5'd0, 5'd0); // lw x0
        tick();
        set_instr(1'b1, 2'b00, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0, 5'd0, 5'd0, 5'd12);
        #1;
        checks++; if ({stall_f, flush_e} !== 2'b00) begin failures++; $display("FAIL x0_load_use got=%0h exp=0", {stall_f, flush_e}); end
        tick();
        checks++; if ({fwd_a_e, fwd_b_e} !== 4'b0) begin failures++; $display("FAIL x0_fwd_mem got=%0h exp=0", {fwd_a_e, fwd_b_e}); end
        set_instr(1'b0, 2'b00, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0, 5'd0, 5'd0, 5'd13);
        tick();
        checks++; if ({fwd_a_e, fwd_b_e} !== 4'b0) begin failures++; $display("FAIL x0_fwd_wb got=%0h exp=0", {fwd_a_e, fwd_b_e}); end
        drain();
    endtask

    task automatic test_load_use();
        set_instr(1'b1, 2'b01, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 5'd1, 5'd0, 5'd5); // lw x5
        tick();
        set_instr(1'b1, 2'b00, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0, 5'd1, 5'd5, 5'd10); // add x10,x1,x5
        #1;
        checks++; if ({stall_f, stall_d, flush_e} !== 3'b111) begin failures++; $display("FAIL lu_stall got=%0h exp=7", {stall_f, stall_d, flush_e}); end
        checks++; if ({flush_d, pc_src} !== 2'b00) begin failures++; $display("FAIL lu_no_flush_d got=%0h exp=0", {flush_d, pc_src}); end
        tick();
        exp_stall++;
        checks++; if (stall_cnt !== CW'(exp_stall)) begin failures++; $display("FAIL lu_stall_cnt got=%0d exp=%0d", stall_cnt, exp_stall); end
        checks++; if ({stall_f, ex_alu_control} !== 4'b0) begin failures++; $display("FAIL lu_bubble got=%0h exp=0", {stall_f, ex_alu_control}); end
        tick();
        checks++; if ({fwd_a_e, fwd_b_e} !== 4'b0001) begin failures++; $display("FAIL lu_fwd_b got=%0h exp=1", {fwd_a_e, fwd_b_e}); end
        checks++; if (ex_alu_control !== 3'b010) begin failures++; $display("FAIL lu_resume got=%0h exp=2", ex_alu_control); end
        checks++; if (stall_cnt !== CW'(exp_stall)) begin failures++; $display("FAIL lu_cnt_once got=%0d exp=%0d", stall_cnt, exp_stall); end
        drain();
    endtask

    task automatic test_branch();
        set_instr(1'b0, 2'b00, 1'b0, 1'b0, 3'b110, 1'b1, 1'b0, 5'd1, 5'd2, 5'd0); // beq
        tick();
        ex_zero = 1'b1;
        set_instr(1'b1, 2'b00, 1'b0, 1'b0, 3'b011, 1'b0, 1'b0, 5'd14, 5'd15, 5'd13);
        #1;
        checks++; if ({pc_src, flush_d, flush_e, stall_f} !== 4'b1110) begin
            failures++; $display("FAIL br_taken got=%0h exp=e", {pc_src, flush_d, flush_e, stall_f}); end
        tick();
        exp_flush++;
        checks++; if (flush_cnt !== CW'(exp_flush)) begin failures++; $display("FAIL br_flush_cnt got=%0d exp=%0d", flush_cnt, exp_flush); end
        checks++; if ({pc_src, ex_alu_control} !== 4'b0) begin failures++; $display("FAIL br_bubble got=%0h exp=0", {pc_src, ex_alu_control}); end
        ex_zero = 1'b0;
        set_instr(1'b0, 2'b00, 1'b0, 1'b0, 3'b110, 1'b1, 1'b0, 5'd1, 5'd2, 5'd0); // beq, not taken
        tick();
        set_instr(1'b1, 2'b00, 1'b0, 1'b0, 3'b101, 1'b0, 1'b0, 5'd14, 5'd15, 5'd13);
        #1;
        checks++; if ({pc_src, flush_d, flush_e} !== 3'b000) begin failures++; $display("FAIL br_not_taken got=%0h exp=0", {pc_src, flush_d, flush_e}); end
        tick();
        checks++; if (flush_cnt !== CW'(exp_flush)) begin failures++; $display("FAIL br_nt_cnt got=%0d exp=%0d", flush_cnt, exp_flush); end
        checks++; if (ex_alu_control !== 3'b101) begin failures++; $display("FAIL br_nt_advance got=%0h exp=5", ex_alu_control); end
        drain();
    endtask

    task automatic test_simultaneous();
        // EX holds a jump that also looks like a load to x5; ID depends on x5
        set_instr(1'b1, 2'b01, 1'b0, 1'b0, 3'b001, 1'b0, 1'b1, 5'd0, 5'd0, 5'd5);
        tick();
        set_instr(1'b1, 2'b00, 1'b0, 1'b0, 3'b111, 1'b0, 1'b0, 5'd5, 5'd0, 5'd9);
        #1;
        checks++; if ({stall_f, stall_d, flush_d, flush_e, pc_src} !== 5'b00111) begin
            failures++; $display("FAIL sim_ctrl got=%0h exp=7", {stall_f, stall_d, flush_d, flush_e, pc_src}); end
        tick();
        exp_flush++;
        checks++; if (stall_cnt !== CW'(exp_stall)) begin failures++; $display("FAIL sim_stall_cnt got=%0d exp=%0d", stall_cnt, exp_stall); end
        checks++; if (flush_cnt !== CW'(exp_flush)) begin failures++; $display("FAIL sim_flush_cnt got=%0d exp=%0d", flush_cnt, exp_flush); end
        checks++; if (ex_alu_control !== 3'b000) begin failures++; $display("FAIL sim_bubble got=%0h exp=0", ex_alu_control); end
        drain();
    endtask

    task automatic test_freeze();
        set_instr(1'b1, 2'b00, 1'b0, 1'b0, 3'b100, 1'b0, 1'b0, 5'd0, 5'd0, 5'd20); // add x20
        tick();
        set_instr(1'b0, 2'b00, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 5'd1, 5'd2, 5'd0);  // sw
        tick();
        set_instr(1'b0, 2'b00, 1'b0, 1'b0, 3'b110, 1'b1, 1'b0, 5'd3, 5'd4, 5'd0);  // beq
        tick();
        dmem_ready = 1'b0;
        ex_zero = 1'b1;
        set_instr(1'b1, 2'b00, 1'b0, 1'b0, 3'b011, 1'b0, 1'b0, 5'd0, 5'd0, 5'd11);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if ({mem_access, stall_f, stall_d, pc_src, flush_d, flush_e} !== 6'b111000) begin
                failures++; $display("FAIL frz_ctrl_%0d got=%0h exp=38", i, {mem_access, stall_f, stall_d, pc_src, flush_d, flush_e}); end
            tick();
            checks++; if ({ex_alu_control, mem_memwrite, wb_rd} !== {3'b110, 1'b1, 5'd20}) begin
                failures++; $display("FAIL frz_hold_%0d got=%0h exp=%0h", i, {ex_alu_control, mem_memwrite, wb_rd}, {3'b110, 1'b1, 5'd20}); end
            checks++; if ({stall_cnt, flush_cnt} !== {CW'(exp_stall), CW'(exp_flush)}) begin
                failures++; $display("FAIL frz_cnt_%0d got=%0h exp=%0h", i, {stall_cnt, flush_cnt}, {CW'(exp_stall), CW'(exp_flush)}); end
        end
        dmem_ready = 1'b1;
        #1;
        checks++; if ({pc_src, flush_e, stall_f} !== 3'b110) begin failures++; $display("FAIL frz_release got=%0h exp=6", {pc_src, flush_e, stall_f}); end
        tick();
        exp_flush++;
        checks++; if (flush_cnt !== CW'(exp_flush)) begin failures++; $display("FAIL frz_flush_cnt got=%0d exp=%0d", flush_cnt, exp_flush); end
        checks++; if ({ex_alu_control, mem_memwrite, wb_rd} !== 9'b0) begin
            failures++; $display("FAIL frz_advance got=%0h exp=0", {ex_alu_control, mem_memwrite, wb_rd}); end
        drain();
    endtask

    task automatic test_reset_mid_freeze();
        set_instr(1'b1, 2'b01, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 5'd1, 5'd0, 5'd6); // lw x6
        tick();
        set_instr(1'b1, 2'b01, 1'b0, 1'b1, 3'b001, 1'b0, 1'b0, 5'd0, 5'd0, 5'd5); // lw x5
        tick();
        set_instr(1'b1, 2'b00, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0, 5'd5, 5'd0, 5'd9);
        dmem_ready = 1'b0;
        #1;
        checks++; if ({stall_f, flush_e} !== 2'b10) begin failures++; $display("FAIL mid_pre got=%0h exp=2", {stall_f, flush_e}); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({stall_f, stall_d, flush_d, flush_e, pc_src, mem_access} !== 6'b0) begin
            failures++; $display("FAIL mid_rst_ctrl got=%0h exp=0", {stall_f, stall_d, flush_d, flush_e, pc_src, mem_access}); end
        checks++; if ({ex_alu_control, ex_alu_src, wb_regwrite, wb_rd, fwd_a_e, fwd_b_e, stall_cnt, flush_cnt} !== '0) begin
            failures++; $display("FAIL mid_rst_regs got=%0h exp=0", {ex_alu_control, ex_alu_src, wb_regwrite, wb_rd, stall_cnt, flush_cnt}); end
        exp_stall = 0;
        exp_flush = 0;
        tick();
        rst_n = 1'b1;
        #1;
        checks++; if ({stall_f, flush_e} !== 2'b00) begin failures++; $display("FAIL mid_after got=%0h exp=0", {stall_f, flush_e}); end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_wb;
        logic [2:0] exp_ex;
        logic       rw;
        logic [1:0] rs;
        for (int c = 0; c < 10; c++) begin
            if (c < 8) begin
                rw = (c % 2 == 0);
                rs = (c % 3 == 2) ? 2'b10 : 2'b00;
                set_instr(rw, rs, 1'b0, 1'b0, 3'(c), 1'b0, 1'b0, 5'd0, 5'd0, 5'(16 + c));
                wb_exp_q.push_back({rw, rs, 5'(16 + c)});
                ex_exp_q.push_back(3'(c));
            end else begin
                set_nop();
                wb_exp_q.push_back(8'h00);
                ex_exp_q.push_back(3'b000);
            end
            tick();
            exp_ex = ex_exp_q.pop_front();
            checks++; if (ex_alu_control !== exp_ex) begin failures++; $display("FAIL b2b_ex_%0d got=%0h exp=%0h", c, ex_alu_control, exp_ex); end
            if (wb_exp_q.size() == 3) begin
                exp_wb = wb_exp_q.pop_front();
                checks++; if ({wb_regwrite, wb_result_src, wb_rd} !== exp_wb) begin
                    failures++; $display("FAIL b2b_wb_%0d got=%0h exp=%0h", c, {wb_regwrite, wb_result_src, wb_rd}, exp_wb); end
            end
        end
        wb_exp_q.delete();
        ex_exp_q.delete();
        drain();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 18; i++) begin
            set_instr(1'b1, 2'b01, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 5'd1, 5'd0, 5'd5);
            tick();
            set_instr(1'b1, 2'b00, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0, 5'd0, 5'd5, 5'd10);
            tick();
            exp_stall = (exp_stall == 15) ? 15 : exp_stall + 1;
            tick();
        end
        checks++; if (stall_cnt !== CW'(exp_stall)) begin failures++; $display("FAIL sat_stall got=%0d exp=%0d", stall_cnt, exp_stall); end
        drain();
        for (int i = 0; i < 18; i++) begin
            set_instr(1'b1, 2'b10, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 5'd0, 5'd0, 5'd1);
            tick();
            set_nop();
            tick();
            exp_flush = (exp_flush == 15) ? 15 : exp_flush + 1;
        end
        checks++; if (flush_cnt !== CW'(exp_flush)) begin failures++; $display("FAIL sat_flush got=%0d exp=%0d", flush_cnt, exp_flush); end
        drain();
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_x0();
        test_load_use();
        test_branch();
        test_simultaneous();
        test_freeze();
        test_reset_mid_freeze();
        test_back_to_back();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
